// File: rtl/controlador_vga.sv
// rtl/controlador_vga.sv - VGA timing generator: pixel divider, h/v counters, sync FSMs
module controlador_vga #(
    parameter int DIV       = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clock,
    input  logic       reset,
    output logic       pixel_tick,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       cambio_linea,
    output logic       inicio_cuadro
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Last count of each segment; the FSMs leave a segment on the tick at its last count.
    localparam logic [9:0] H_END_VISIBLE = 10'(H_VISIBLE - 1);
    localparam logic [9:0] H_END_FRONT   = 10'(H_VISIBLE + H_FRONT - 1);
    localparam logic [9:0] H_END_SYNC    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] H_END_LINE    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_END_VISIBLE = 10'(V_VISIBLE - 1);
    localparam logic [9:0] V_END_FRONT   = 10'(V_VISIBLE + V_FRONT - 1);
    localparam logic [9:0] V_END_SYNC    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] V_END_FRAME   = 10'(V_TOTAL - 1);
    localparam logic [4:0] DIV_LAST      = 5'(DIV - 1);

    typedef enum logic [1:0] {
        HS_VISIBLE,
        HS_FRONT,
        HS_SYNC,
        HS_BACK
    } h_state_t;

    typedef enum logic [1:0] {
        VS_VISIBLE,
        VS_FRONT,
        VS_SYNC,
        VS_BACK
    } v_state_t;

    h_state_t   h_state, h_next;
    v_state_t   v_state, v_next;
    logic [4:0] div_cnt, div_next;
    logic [9:0] x_cnt, x_next;
    logic [9:0] y_cnt, y_next;
    logic       tick_raw;
    logic       end_of_line;
    logic       end_of_frame;

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt <= '0;
            x_cnt   <= '0;
            y_cnt   <= '0;
            h_state <= HS_VISIBLE;
            v_state <= VS_VISIBLE;
        end else begin
            div_cnt <= div_next;
            x_cnt   <= x_next;
            y_cnt   <= y_next;
            h_state <= h_next;
            v_state <= v_next;
        end
    end

    always_comb begin
        tick_raw     = (div_cnt == DIV_LAST);
        end_of_line  = tick_raw && (x_cnt == H_END_LINE);
        end_of_frame = end_of_line && (y_cnt == V_END_FRAME);

        div_next = tick_raw ? 5'd0 : div_cnt + 5'd1;

        x_next = x_cnt;
        if (tick_raw) begin
            x_next = end_of_line ? 10'd0 : x_cnt + 10'd1;
        end

        y_next = y_cnt;
        if (end_of_line) begin
            y_next = end_of_frame ? 10'd0 : y_cnt + 10'd1;
        end
    end

    // Horizontal FSM moves on the same tick that moves x across a segment boundary.
    always_comb begin
        h_next = h_state;
        if (tick_raw) begin
            case (h_state)
                HS_VISIBLE: if (x_cnt == H_END_VISIBLE) h_next = HS_FRONT;
                HS_FRONT:   if (x_cnt == H_END_FRONT)   h_next = HS_SYNC;
                HS_SYNC:    if (x_cnt == H_END_SYNC)    h_next = HS_BACK;
                HS_BACK:    if (x_cnt == H_END_LINE)    h_next = HS_VISIBLE;
                default:                                h_next = HS_VISIBLE;
            endcase
        end
    end

    always_comb begin
        v_next = v_state;
        if (end_of_line) begin
            case (v_state)
                VS_VISIBLE: if (y_cnt == V_END_VISIBLE) v_next = VS_FRONT;
                VS_FRONT:   if (y_cnt == V_END_FRONT)   v_next = VS_SYNC;
                VS_SYNC:    if (y_cnt == V_END_SYNC)    v_next = VS_BACK;
                VS_BACK:    if (y_cnt == V_END_FRAME)   v_next = VS_VISIBLE;
                default:                                v_next = VS_VISIBLE;
            endcase
        end
    end

    // Reset masks the outputs immediately so an abandoned scan never leaks a pulse or sync.
    always_comb begin
        pixel_tick    = tick_raw && !reset;
        cambio_linea  = end_of_line && !reset;
        inicio_cuadro = end_of_frame && !reset;
        hsync         = reset || (h_state != HS_SYNC);
        vsync         = reset || (v_state != VS_SYNC);
        video_on      = reset || ((h_state == HS_VISIBLE) && (v_state == VS_VISIBLE));
        x             = x_cnt;
        y             = y_cnt;
    end

endmodule

// File: doc/controlador_vga.md
CONTROLADOR_VGA -- requirements
Module: controlador_vga

Interface
REQ-001 Parameter DIV, default 2, meaning system clocks per pixel; legal range 1..16.
REQ-002 Parameters H_VISIBLE/H_FRONT/H_SYNC/H_BACK, defaults 640/16/96/48, meaning horizontal segment lengths in pixels; total 800.
REQ-003 Parameters V_VISIBLE/V_FRONT/V_SYNC/V_BACK, defaults 480/10/2/33, meaning vertical segment lengths in lines; total 525.
REQ-004 clock  in  1  single system clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 pixel_tick  out  1  one-clock pulse marking each pixel period.
REQ-007 hsync  out  1  horizontal sync, active low.
REQ-008 vsync  out  1  vertical sync, active low.
REQ-009 video_on  out  1  high while the current pixel is in the visible area.
REQ-010 x  out  10  current horizontal count, 0..799.
REQ-011 y  out  10  current vertical count, 0..524.
REQ-012 cambio_linea  out  1  one-clock pulse on the tick that ends a line.
REQ-013 inicio_cuadro  out  1  one-clock pulse on the tick that ends a frame.

Function
REQ-014 Divider counter SHALL count 0..DIV-1 and wrap; pixel_tick=1 exactly when the divider equals DIV-1; for DIV=1, pixel_tick=1 every clock outside reset.
REQ-015 Horizontal counter SHALL advance by 1 only on clocks with pixel_tick=1 and SHALL hold otherwise.
REQ-016 Horizontal counter SHALL wrap from 799 to 0; no value above 799 SHALL ever appear.
REQ-017 Vertical counter SHALL advance by 1 only on a clock where pixel_tick=1 and the horizontal count is 799; it SHALL wrap from 524 to 0.
REQ-018 Horizontal FSM SHALL track the horizontal count: H_VISIBLE for 0-639, H_FRONT for 640-655, H_SYNC for 656-751, H_BACK for 752-799; it SHALL then return to H_VISIBLE.
REQ-019 Vertical FSM SHALL track the vertical count: V_VISIBLE for 0-479, V_FRONT for 480-489, V_SYNC for 490-491, V_BACK for 492-524; it SHALL then return to V_VISIBLE.
REQ-020 FSM transitions SHALL occur on the same edge as the counter change that crosses the boundary, so state and count never disagree.
REQ-021 hsync SHALL be 0 exactly in H_SYNC; vsync SHALL be 0 exactly in V_SYNC.
REQ-022 video_on SHALL be 1 exactly when the FSMs are in H_VISIBLE and V_VISIBLE.
REQ-023 x and y SHALL equal the horizontal and vertical counts in every cycle, with no extra latency relative to hsync/vsync/video_on.
REQ-024 cambio_linea SHALL be 1 when pixel_tick=1 and x=799.
REQ-025 inicio_cuadro SHALL be 1 when pixel_tick=1, x=799 and y=524; on that clock cambio_linea SHALL also be 1.
REQ-026 Segment boundaries SHALL be derived from the parameters only, with no hard-coded constants; 10-bit counters SHALL suffice for any parameter set totalling at most 1024.

Reset
REQ-027 While reset=1 at a rising edge, the block SHALL load divider=0, x=0, y=0, H_VISIBLE and V_VISIBLE; reset SHALL take priority over any tick.
REQ-028 While reset is high, pixel_tick, cambio_linea and inicio_cuadro SHALL be 0, hsync=1, vsync=1, video_on=1, x=0, y=0.
REQ-029 Reset asserted mid-line or mid-frame SHALL abandon the scan, with no partial pulses; after release, the first pixel_tick SHALL occur DIV clocks later.

Verification
REQ-030 DIV=2, reset for 3 clocks then release -> pixel_tick on clocks 2,4,6,...; x increments on each tick, x=0..799 over 1600 clocks, then x=0 with y=1; cambio_linea pulses once, at x=799.
REQ-031 Full line at DIV=2 -> hsync low for exactly 96 ticks (x=656..751); video_on high for x=0..639, low for x=640..799.
REQ-032 Full frame at DIV=1 -> exactly 420000 clocks between inicio_cuadro pulses; vsync low only for y=490..491, i.e. 1600 clocks; video_on never high when y is 480 or more.
REQ-033 Reset asserted at x=700, y=300 -> on the next edge x=0, y=0, hsync=1, vsync=1, no pulses; the scan restarts cleanly.
REQ-034 DIV=3 -> x holds for 3 clocks per value; the check x==expected holds on every clock for 2 full lines, 4800 clocks.
REQ-035 Simultaneous wrap at x=799, y=524 -> both pulses high for one clock; the next state is x=0, y=0, video_on=1.
